// File: rtl/uart_pkg.sv
// Shared UART definitions: payload and counter widths, receiver FSM encoding.
package uart_pkg;

  localparam int unsigned UART_PAYLOAD_BITS = 8;
  localparam int unsigned UART_COUNT_LEN    = 16;

  typedef logic [UART_PAYLOAD_BITS-1:0] uart_byte_t;

  typedef enum logic [2:0] {
    RX_WAIT_HIGH,
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO for received UART data.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  uart_byte_t push_data,
  input  logic       pop,
  output uart_byte_t head,
  output logic       empty,
  output logic       full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  uart_byte_t  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Extra MSB on each pointer tells full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; a pop on a full FIFO frees the slot the push lands in.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: rxd synchronizer, bit-timing FSM, shift register, receive FIFO.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         uart_rxd,
  input  logic [UART_COUNT_LEN-1:0]    cycles_per_bit,
  output logic [UART_PAYLOAD_BITS-1:0] rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic                         rx_frame_err,
  output logic                         rx_overrun,
  output logic                         rx_busy
);

  localparam int unsigned BIT_CNT_W = $clog2(UART_PAYLOAD_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(UART_PAYLOAD_BITS - 1);

  logic [SYNC_STAGES-1:0]    sync;
  logic [SYNC_STAGES-1:0]    settle;
  logic                      rxs;
  rx_state_e                 state;
  logic [UART_COUNT_LEN-1:0] cpb;
  logic [UART_COUNT_LEN-1:0] cnt;
  logic [BIT_CNT_W-1:0]      bit_cnt;
  uart_byte_t                shift;
  logic                      push_c;
  logic                      fifo_empty;
  logic                      fifo_full;
  uart_byte_t                fifo_head;

  assign rxs = sync[SYNC_STAGES-1];

  // Synchronizer chain; settle marks when reset's preset ones have flushed out.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync   <= '1;
      settle <= '0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], uart_rxd};
      settle <= {settle[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Good stop bit: hand the assembled byte to the FIFO.
  assign push_c = (state == RX_STOP) && (cnt == cpb) && rxs;

  // Frame FSM with bit timing, data shift and registered status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= RX_WAIT_HIGH;
      cpb          <= '0;
      cnt          <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      case (state)
        RX_WAIT_HIGH: begin
          // Only trust a high line once real samples have reached rxs.
          if (rxs && settle[SYNC_STAGES-1]) state <= RX_IDLE;
        end
        RX_IDLE: begin
          if (!rxs) begin
            cpb     <= cycles_per_bit;
            cnt     <= '0;
            state   <= RX_START;
            rx_busy <= 1'b1;
          end
        end
        RX_START: begin
          if (cnt == (cpb >> 1)) begin
            if (!rxs) begin
              cnt     <= '0;
              bit_cnt <= '0;
              state   <= RX_DATA;
            end else begin
              state   <= RX_IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + UART_COUNT_LEN'(1);
          end
        end
        RX_DATA: begin
          if (cnt == cpb) begin
            shift   <= {rxs, shift[UART_PAYLOAD_BITS-1:1]};
            cnt     <= '0;
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == LAST_BIT) state <= RX_STOP;
          end else begin
            cnt <= cnt + UART_COUNT_LEN'(1);
          end
        end
        RX_STOP: begin
          if (cnt == cpb) begin
            cnt     <= '0;
            rx_busy <= 1'b0;
            if (rxs) begin
              // A pop in the same cycle makes room, so only a stalled full FIFO drops.
              rx_overrun <= fifo_full && !rx_ready;
              state      <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + UART_COUNT_LEN'(1);
          end
        end
        default: begin
          state   <= RX_WAIT_HIGH;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_c),
    .push_data (shift),
    .pop       (rx_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rx_valid = !fifo_empty;
  assign rx_data  = fifo_head;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: per-frame vector table plus multi-frame corner sequences.
module tb_uart_receiver;

  logic        clk;
  logic        resetn;
  logic        uart_rxd;
  logic [15:0] cycles_per_bit;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_frame_err;
  logic        rx_overrun;
  logic        rx_busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int ov_cyc = -1;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic [15:0] cpb;
    logic        exp_valid;
    int          exp_fe;
  } vec_t;

  vec_t vecs[7];

  uart_receiver #(
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .uart_rxd       (uart_rxd),
    .cycles_per_bit (cycles_per_bit),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_frame_err   (rx_frame_err),
    .rx_overrun     (rx_overrun),
    .rx_busy        (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: value n during the cycle that follows posedge n.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (rx_overrun === 1'b1) begin
      ov_cnt <= ov_cnt + 1;
      ov_cyc <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serial transmitter model: start, 8 data LSB first, stop; p clocks per bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int p);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      tick(p);
    end
  endtask

  task automatic pop_check(input string nm, input logic [7:0] exp);
    check({nm, " valid"}, 32'(rx_valid), 32'd1);
    check({nm, " data"}, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic check_empty(input string nm);
    check({nm, " valid"}, 32'(rx_valid), 32'd0);
    check({nm, " data"}, 32'(rx_data), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int m;
    int fe0;
    int ov0;
    int bad;

    vecs[0] = '{8'hA5, 1'b1, 16'd2,  1'b1, 0};
    vecs[1] = '{8'h3C, 1'b1, 16'd4,  1'b1, 0};
    vecs[2] = '{8'hC3, 1'b1, 16'd7,  1'b1, 0};
    vecs[3] = '{8'h81, 1'b1, 16'd15, 1'b1, 0};
    vecs[4] = '{8'h7E, 1'b0, 16'd15, 1'b0, 1};
    vecs[5] = '{8'hFF, 1'b1, 16'd3,  1'b1, 0};
    vecs[6] = '{8'h00, 1'b1, 16'd2,  1'b1, 0};

    resetn         = 1'b0;
    uart_rxd       = 1'b1;
    rx_ready       = 1'b0;
    cycles_per_bit = 16'd15;
    tick(3);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_frame_err", 32'(rx_frame_err), 32'd0);
    check("reset rx_overrun", 32'(rx_overrun), 32'd0);
    check("reset rx_busy", 32'(rx_busy), 32'd0);
    resetn = 1'b1;
    tick(10);

    // Single frames over several divisors, including the minimum of 2.
    for (int i = 0; i < 7; i++) begin
      cycles_per_bit = vecs[i].cpb;
      tick(5);
      fe0 = fe_cnt;
      send_frame(vecs[i].data, vecs[i].stop, int'(vecs[i].cpb) + 1);
      uart_rxd = 1'b1;
      tick(3 * (int'(vecs[i].cpb) + 1) + 10);
      check($sformatf("vec%0d valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d data", i), 32'(rx_data),
            vecs[i].exp_valid ? 32'(vecs[i].data) : 32'd0);
      check($sformatf("vec%0d frame_err", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      check($sformatf("vec%0d drained", i), 32'(rx_valid), 32'd0);
    end

    // Back-to-back frames at cpb=15, with first rx_valid latency.
    cycles_per_bit = 16'd15;
    tick(10);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    n   = cyc;
    fork
      begin
        send_frame(8'h55, 1'b1, 16);
        send_frame(8'hA3, 1'b1, 16);
        send_frame(8'h00, 1'b1, 16);
        send_frame(8'hFF, 1'b1, 16);
      end
      begin
        for (int i = 0; i < 400 && rx_valid !== 1'b1; i++) tick(1);
        check("loopback first valid cycle", 32'(cyc - n), 32'd155);
      end
    join
    tick(10);
    check("loopback frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("loopback overrun", 32'(ov_cnt - ov0), 32'd0);
    pop_check("loopback b0", 8'h55);
    pop_check("loopback b1", 8'hA3);
    pop_check("loopback b2", 8'h00);
    pop_check("loopback b3", 8'hFF);
    check_empty("loopback end");

    // Start glitch: 4-clock low pulse is rejected at the mid-start check.
    tick(10);
    n = cyc;
    uart_rxd = 1'b0;
    tick(4);
    uart_rxd = 1'b1;
    tick(6);
    check("glitch busy at mid-start", 32'(rx_busy), 32'd1);
    tick(1);
    check("glitch busy after mid-start", 32'(rx_busy), 32'd0);
    check("glitch cycle", 32'(cyc - n), 32'd11);
    tick(40);
    check_empty("glitch nothing pushed");

    // Framing error, line held low, then recovery.
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 16);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (rx_busy !== 1'b0) bad = 1;
    end
    check("ferr single pulse", 32'(fe_cnt - fe0), 32'd1);
    check("ferr no start while low", 32'(bad), 32'd0);
    check_empty("ferr byte dropped");
    uart_rxd = 1'b1;
    tick(10);
    send_frame(8'h81, 1'b1, 16);
    tick(10);
    pop_check("ferr recovery", 8'h81);
    check("ferr count after recovery", 32'(fe_cnt - fe0), 32'd1);
    check_empty("ferr end");

    // Overrun: five frames with no consumer.
    tick(10);
    ov0 = ov_cnt;
    n   = cyc;
    send_frame(8'h01, 1'b1, 16);
    send_frame(8'h02, 1'b1, 16);
    send_frame(8'h03, 1'b1, 16);
    send_frame(8'h04, 1'b1, 16);
    send_frame(8'h05, 1'b1, 16);
    tick(10);
    check("overrun single pulse", 32'(ov_cnt - ov0), 32'd1);
    check("overrun pulse cycle", 32'(ov_cyc - n), 32'd795);
    pop_check("overrun b0", 8'h01);
    pop_check("overrun b1", 8'h02);
    pop_check("overrun b2", 8'h03);
    pop_check("overrun b3", 8'h04);
    check_empty("overrun end");

    // Full FIFO with a pop landing exactly on the push edge.
    tick(10);
    ov0 = ov_cnt;
    n   = cyc;
    m   = n + 640;
    fork
      begin
        send_frame(8'h01, 1'b1, 16);
        send_frame(8'h02, 1'b1, 16);
        send_frame(8'h03, 1'b1, 16);
        send_frame(8'h04, 1'b1, 16);
        send_frame(8'h06, 1'b1, 16);
      end
      begin
        while (cyc < m + 154) tick(1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    tick(10);
    check("full+pop no overrun", 32'(ov_cnt - ov0), 32'd0);
    pop_check("full+pop b0", 8'h02);
    pop_check("full+pop b1", 8'h03);
    pop_check("full+pop b2", 8'h04);
    pop_check("full+pop b3", 8'h06);
    check_empty("full+pop end");

    // Reset during data bit 4 with the line held low.
    tick(10);
    send_frame(8'h77, 1'b1, 16);
    tick(10);
    check("pre-reset byte stored", 32'(rx_valid), 32'd1);
    fe0 = fe_cnt;
    n   = cyc;
    uart_rxd = 1'b0;
    tick(88);
    check("pre-reset busy", 32'(rx_busy), 32'd1);
    resetn = 1'b0;
    tick(3);
    check("midreset rx_data", 32'(rx_data), 32'd0);
    check("midreset rx_valid", 32'(rx_valid), 32'd0);
    check("midreset rx_frame_err", 32'(rx_frame_err), 32'd0);
    check("midreset rx_overrun", 32'(rx_overrun), 32'd0);
    check("midreset rx_busy", 32'(rx_busy), 32'd0);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (rx_busy !== 1'b0) bad = 1;
    end
    check("post-reset waits for high", 32'(bad), 32'd0);
    check("post-reset no frame_err", 32'(fe_cnt - fe0), 32'd0);
    check_empty("post-reset fifo");
    uart_rxd = 1'b1;
    tick(10);
    send_frame(8'h5A, 1'b1, 16);
    tick(10);
    pop_check("post-reset frame", 8'h5A);
    check_empty("post-reset end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART receive engine paired with the existing `uart_tx`. It oversamples the asynchronous `uart_rxd` pin using the same runtime `cycles_per_bit` divisor, reconstructs 8N1 frames LSB-first, and reports framing errors. Received bytes go into a small first-word-fall-through FIFO with a valid/ready pop interface toward the SoC bus/peripheral wrapper.

## Interface
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: flops in the `uart_rxd` synchronizer chain, ≥2.
- `clk` input 1: system clock.
- `resetn` input 1: synchronous, active-low reset.
- `uart_rxd` input 1: asynchronous serial line, idle high.
- `cycles_per_bit` input 16: a bit period lasts `cycles_per_bit+1` clocks, the same convention as `uart_tx`; legal range ≥2.
- `rx_data` output 8: FIFO head byte; 0 when FIFO empty.
- `rx_valid` output 1: FIFO non-empty.
- `rx_ready` input 1: consumer pops the head when `rx_valid && rx_ready`.
- `rx_frame_err` output 1: one-cycle pulse when the stop bit samples low.
- `rx_overrun` output 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `rx_busy` output 1: high in START, DATA and STOP.

## Operation
- Synchronizer: `SYNC_STAGES` flops, all reset to 1. `rxs` is the last stage. All FSM logic uses only `rxs`.
- FSM states: WAIT_HIGH (the reset state), IDLE, START, DATA, STOP.
  - WAIT_HIGH: go to IDLE when `rxs==1`. This prevents a false start after reset or after a break.
  - IDLE: when `rxs==0`, latch `cpb <= cycles_per_bit`, clear `cnt`, go to START. `cpb` holds for the whole frame. Changes to the input mid-frame are ignored.
  - START: at `cnt==cpb>>1` (mid start bit):
    - if `rxs==0`, clear `cnt` and `bit_cnt`, go to DATA;
    - else (glitch) go to IDLE, with no flag.
  - DATA: at `cnt==cpb`, sample `rxs` into `shift[7]` and shift right (LSB first), clear `cnt`, increment `bit_cnt`. After the 8th sample go to STOP.
  - STOP: at `cnt==cpb`, sample `rxs`:
    - if 1, push `shift` into the FIFO and go to IDLE;
    - if 0, pulse `rx_frame_err`, discard the byte, go to WAIT_HIGH.
- `cnt` is 16-bit. It increments every cycle in START, DATA and STOP and is cleared on each sample event. It never wraps because it cannot exceed `cpb`.
- Only one stop bit is checked. Extra stop bits and idle time are absorbed in IDLE.
- FIFO pointers are `log2(FIFO_DEPTH)+1` bits, wrapping naturally.
  - Full when the pointers differ only in the MSB.
  - Empty when the pointers are equal.
- Push when full:
  - with a pop in the same cycle, both succeed, there is no overrun, and the count is unchanged;
  - without a pop, the byte is dropped and `rx_overrun` pulses.
- Pop when empty is ignored.
- Push and pop on an empty FIFO in the same cycle: the pop is ignored (`rx_valid` was 0), and the byte is stored.
- Reset at any point (including mid-frame) has these effects:
  - FSM returns to WAIT_HIGH.
  - The synchronizer is forced to 1.
  - The FIFO empties and the partial byte is lost.
  - Counters clear and pulses deassert.

## Timing
- Reset values: `rx_data=0`, `rx_valid=0`, `rx_frame_err=0`, `rx_overrun=0`, `rx_busy=0`.
- Let `E` be the clock edge that first registers `uart_rxd` low in synchronizer stage 1.
  - `rxs` goes low after `E+SYNC_STAGES-1`.
  - START is entered at `t0 = E+SYNC_STAGES`.
- Sample points, with `h = cpb>>1` and `P = cpb+1`:
  - start-bit check at `t0+h`;
  - data bit k (k=0..7) at `t0+h+(k+1)·P`;
  - stop bit at `t0+h+9·P`.
- Push happens on the stop-sample edge.
  - `rx_valid`/`rx_data` update on the following cycle when the FIFO was empty.
  - `rx_frame_err`/`rx_overrun` are high during the cycle after the stop sample.
- The next IDLE cycle is `t0+h+9·P+1`. Back-to-back frames from `uart_tx` (10·P per frame) are therefore received with no loss.
- Pop: the head advances on the edge where `rx_valid && rx_ready`. Next-entry data is visible the following cycle.
- `rx_busy` follows the FSM state, registered.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding: `RX_WAIT_HIGH`, `RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`;
  - `UART_PAYLOAD_BITS=8`;
  - `UART_COUNT_LEN=16`, shared with `uart_tx`.
- One sub-module, `uart_rx_fifo`:
  - parameter `DEPTH`, width 8;
  - first-word-fall-through;
  - ports `push`, `push_data`, `pop`, `head`, `empty`, `full`.
- Synchronizer, FSM and shift register stay in `uart_receiver`.

## Test plan
- Loopback `uart_tx` → `uart_receiver` with `cycles_per_bit=15`; send 0x55, 0xA3, 0x00, 0xFF back-to-back. Required: the same four bytes pop in order, no error pulses, and `rx_valid` rises exactly `t0+7+144+1`.
- Start glitch: `uart_rxd` low for 4 clocks, then high, with `cycles_per_bit=15`. Required: return to IDLE, nothing pushed, `rx_busy` low again by the mid-start point +1.
- Framing error: send 0x3C with the stop bit driven 0, then hold the line low 40 clocks, then release and send 0x81. Required:
  - `rx_frame_err` is a single pulse;
  - 0x3C is not stored;
  - nothing starts until the line goes high;
  - 0x81 is received correctly.
- Overrun: `rx_ready=0`, `FIFO_DEPTH=4`, send 5 bytes 0x01..0x05. Required:
  - `rx_overrun` pulses once, on the 5th stop sample;
  - pops yield 0x01..0x04.
- Full with simultaneous pop: fill 4 entries, assert `rx_ready` for exactly the stop-sample cycle of byte 0x06. Required: no overrun, and the FIFO holds 0x02, 0x03, 0x04, 0x06.
- Reset mid-frame: assert `resetn=0` during data bit 4 while the line stays low. Required:
  - outputs return to reset values;
  - the FSM stays in WAIT_HIGH until the line goes high;
  - the next frame, 0x5A, is received cleanly.
